// File: rtl/afu_cmult_stream.sv
// Streaming complex-multiply AFU core.
// Input lines go through an input FIFO and then a fixed-latency lane-operation
// pipeline. Results are written to an output FIFO. Issue is credit-gated, so
// every line in flight always has a reserved output slot.
// The datapath is fp32: DATA_WIDTH must stay 32.
module afu_cmult_stream #(
  parameter int LINE_WIDTH      = 512,
  parameter int DATA_WIDTH      = 32,
  parameter int N_LANES         = LINE_WIDTH / (2 * DATA_WIDTH),
  parameter int BUFF_DEPTH_BITS = 3,
  parameter int MULT_LATENCY    = 6    // must be >= 3: stage 0 plus two arithmetic stages plus delay
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [31:0]                ctx_length,
  input  logic [LINE_WIDTH-1:0]      input_fifo_din,
  input  logic                       input_fifo_we,
  output logic                       input_fifo_full,
  output logic                       input_fifo_almost_full,
  output logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
  output logic [LINE_WIDTH-1:0]      output_fifo_dout,
  input  logic                       output_fifo_re,
  output logic                       output_fifo_empty,
  output logic                       output_fifo_almost_empty,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                lines_out
);

  localparam int AW    = BUFF_DEPTH_BITS;
  localparam int CW    = BUFF_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << BUFF_DEPTH_BITS;
  localparam int LANE  = 2 * DATA_WIDTH;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // fp32 multiply, round-to-nearest-even; subnormals flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, rnd, sticky, inc;
    logic [47:0] prod;
    logic [22:0] m;
    logic [31:0] r;
    int          e;
    s    = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (prod[47]) begin
      e = int'(a[30:23]) + int'(b[30:23]) - 126;
      m = prod[46:24]; rnd = prod[23]; sticky = |prod[22:0];
    end else begin
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      m = prod[45:23]; rnd = prod[22]; sticky = |prod[21:0];
    end
    inc = rnd & (sticky | m[0]);
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      r = QNAN;
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      r = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? QNAN : {s, 8'hFF, 23'd0};
    else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) r = {s, 31'd0};
    else if (e >= 255) r = {s, 8'hFF, 23'd0};
    else if (e <= 0)   r = {s, 31'd0};
    else               r = {s, {8'(e), m} + 31'(inc)};   // a mantissa carry bumps the exponent
    return r;
  endfunction

  // fp32 add, round-to-nearest-even; subnormals flush to signed zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [26:0] mx, my, sh;
    logic [27:0] sum;
    logic        sticky, inc;
    int          d, e, lz;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) r = QNAN;
    else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) r = (a[31] == b[31]) ? a : QNAN;
    else if (a[30:23] == 8'hFF) r = a;
    else if (b[30:23] == 8'hFF) r = b;
    else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) r = {a[31] & b[31], 31'd0};
    else if (a[30:23] == 8'h00) r = b;
    else if (b[30:23] == 8'h00) r = a;
    else begin
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else                    begin x = b; y = a; end
      d  = int'(x[30:23]) - int'(y[30:23]);
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      if (d > 26) sh = 27'd1;              // fully shifted out: only the sticky bit survives
      else begin
        sticky = |(my & ((27'd1 << d) - 27'd1));
        sh     = (my >> d) | 27'(sticky);
      end
      sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
      e   = int'(x[30:23]);
      if (sum == '0) r = 32'd0;            // exact cancellation gives +0
      else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 1;
        end else begin
          lz = 0;
          for (int i = 0; i <= 26; i++) if (sum[i]) lz = 26 - i;
          sum = sum << lz;
          e   = e - lz;
        end
        inc = sum[2] & (sum[3] | sum[1] | sum[0]);
        if (e >= 255)    r = {x[31], 8'hFF, 23'd0};
        else if (e <= 0) r = {x[31], 31'd0};
        else             r = {x[31], {8'(e), sum[25:3]} + 31'(inc)};
      end
    end
    return r;
  endfunction

  state_t state, state_nxt;
  logic [1:0]  job_mode;
  logic [31:0] job_len, issued;
  logic [CW-1:0] in_cnt, out_cnt, inflight;
  logic [AW-1:0] in_wr, in_rd, out_wr, out_rd;
  logic [LINE_WIDTH-1:0] in_mem  [DEPTH];
  logic [LINE_WIDTH-1:0] out_mem [DEPTH];
  logic in_push, in_empty, out_push, out_pop, issue, start_ok;
  logic [MULT_LATENCY:0] vld;
  logic [LINE_WIDTH-1:0] s0_line, s1_raw, s2_line, s2_next;
  logic [LINE_WIDTH-1:0] dly [MULT_LATENCY-2];

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign in_empty = (in_cnt == '0);
  // A credit is an output slot not yet claimed by a stored or in-flight line.
  assign issue    = (state == S_RUN) && !in_empty && (issued < job_len) &&
                    (({1'b0, inflight} + {1'b0, out_cnt}) < (CW + 1)'(DEPTH));
  assign in_push  = input_fifo_we && (!input_fifo_full || issue);
  assign out_push = vld[MULT_LATENCY];
  assign out_pop  = output_fifo_re && !output_fifo_empty;

  assign input_fifo_full          = (in_cnt == CW'(DEPTH));
  assign input_fifo_almost_full   = (in_cnt >= CW'(DEPTH - 4));
  assign input_fifo_count         = in_cnt[AW-1:0];   // reads 0 when full; full disambiguates
  assign output_fifo_empty        = (out_cnt == '0);
  assign output_fifo_almost_empty = (out_cnt <= CW'(2));

  // State register.
  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (ctx_length == '0) ? S_DONE : S_RUN;
      S_RUN:          if (issued == job_len) state_nxt = S_DRAIN;
      S_DRAIN:        if (lines_out == job_len) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // Job context, progress counters and in-flight tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_mode  <= 2'd0;
      job_len   <= '0;
      issued    <= '0;
      lines_out <= '0;
      inflight  <= '0;
    end else begin
      if (start_ok) begin
        job_mode  <= mode;
        job_len   <= ctx_length;
        issued    <= '0;
        lines_out <= '0;
      end else begin
        if (issue) issued <= issued + 32'd1;
        if (out_push && lines_out != '1) lines_out <= lines_out + 32'd1;
      end
      inflight <= inflight + CW'(issue) - CW'(out_push);
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + AW'(1);
      if (issue)   in_rd <= in_rd + AW'(1);
      in_cnt <= in_cnt + CW'(in_push) - CW'(issue);
    end
  end

  // FIFO storage writes.
  // NOTE: storage arrays carry no reset; the pointers and counts decide which entries are valid.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= input_fifo_din;
    if (out_push) out_mem[out_wr] <= dly[MULT_LATENCY-3];
  end

  // Output FIFO pointers, occupancy and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr           <= '0;
      out_rd           <= '0;
      out_cnt          <= '0;
      output_fifo_dout <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop) begin
        out_rd           <= out_rd + AW'(1);
        output_fifo_dout <= out_mem[out_rd];
      end
      out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
    end
  end

  // Pipeline valid chain: a pop at cycle t writes the output at t+MULT_LATENCY+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld <= '0;
    else       vld <= {vld[MULT_LATENCY-1:0], issue};
  end

  // Pipeline data registers; their validity is tracked by vld.
  always_ff @(posedge clk) begin
    s0_line <= in_mem[in_rd];
    s1_raw  <= s0_line;
    s2_line <= s2_next;
    dly[0]  <= s2_line;
    for (int i = 1; i < MULT_LATENCY - 2; i++) dly[i] <= dly[i-1];
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    localparam int LO  = LANE * k;
    localparam int NLO = LANE * ((k + 1) % N_LANES);
    logic [31:0] ar, ai, br, bi, nb_re, nb_im, p_rr, p_ii, p_ri, p_ir;

    assign ar    = s0_line[LO +: DATA_WIDTH];
    assign ai    = s0_line[LO + DATA_WIDTH +: DATA_WIDTH];
    assign nb_re = s0_line[NLO +: DATA_WIDTH];
    assign nb_im = s0_line[NLO + DATA_WIDTH +: DATA_WIDTH];

    // Second operand: ring neighbour, its conjugate, or the lane itself.
    always_comb begin
      br = ar;
      bi = ai;
      case (job_mode)
        2'd0:    begin br = nb_re; bi = nb_im; end
        2'd1:    begin br = nb_re; bi = {~nb_im[31], nb_im[30:0]}; end
        default: begin br = ar;    bi = ai;    end
      endcase
    end

    // Stage 1: the four real partial products of (ar + j*ai)(br + j*bi).
    always_ff @(posedge clk) begin
      p_rr <= fp_mul(ar, br);
      p_ii <= fp_mul(ai, bi);
      p_ri <= fp_mul(ar, bi);
      p_ir <= fp_mul(ai, br);
    end

    // Stage 2: recombine into re/im; passthrough takes the raw lane at the same depth.
    assign s2_next[LO +: LANE] = (job_mode == 2'd3) ? s1_raw[LO +: LANE]
                               : {fp_add(p_ri, p_ir), fp_add(p_rr, {~p_ii[31], p_ii[30:0]})};
  end

endmodule

// File: tb/tb_afu_cmult_stream.sv
// Scoreboard bench for afu_cmult_stream: stimulus pushes expected lines into
// a queue, and a monitor pops the output FIFO and compares in order.
`timescale 1ns/1ps
module tb_afu_cmult_stream;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [31:0]   ctx_length;
  logic [LW-1:0] input_fifo_din;
  logic          input_fifo_we;
  logic          input_fifo_full;
  logic          input_fifo_almost_full;
  logic [2:0]    input_fifo_count;
  logic [LW-1:0] output_fifo_dout;
  logic          output_fifo_re;
  logic          output_fifo_empty;
  logic          output_fifo_almost_empty;
  logic          busy;
  logic          done;
  logic [31:0]   lines_out;

  afu_cmult_stream dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ctx_length(ctx_length),
    .input_fifo_din(input_fifo_din), .input_fifo_we(input_fifo_we),
    .input_fifo_full(input_fifo_full), .input_fifo_almost_full(input_fifo_almost_full),
    .input_fifo_count(input_fifo_count), .output_fifo_dout(output_fifo_dout),
    .output_fifo_re(output_fifo_re), .output_fifo_empty(output_fifo_empty),
    .output_fifo_almost_empty(output_fifo_almost_empty), .busy(busy), .done(done),
    .lines_out(lines_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit drain_en = 1'b0;
  logic [LW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] r0, i0, r1, i1, r2, i2);
    logic [LW-1:0] l;
    l = '0;
    l[31:0]    = r0; l[63:32]   = i0;
    l[95:64]   = r1; l[127:96]  = i1;
    l[159:128] = r2; l[191:160] = i2;
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  // Monitor: pop whenever allowed and data is present, compare the registered dout next cycle.
  initial begin : monitor
    logic [LW-1:0] e;
    bit pend;
    pend = 1'b0;
    output_fifo_re = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_line: got %h expected none", output_fifo_dout);
        end else begin
          e = exp_q.pop_front();
          if (output_fifo_dout !== e) begin
            n_fail++;
            $display("FAIL line_data: got %h expected %h", output_fifo_dout, e);
          end
        end
      end
      if (drain_en && !output_fifo_empty && !reset) begin
        output_fifo_re = 1'b1;
        pend = 1'b1;
      end else begin
        output_fifo_re = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_line(input logic [LW-1:0] l);
    int t;
    t = 0;
    while (input_fifo_full && t < 1000) begin @(negedge clk); t++; end
    if (input_fifo_full) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got full=1 expected space within 1000 cycles");
      return;
    end
    input_fifo_din = l;
    input_fifo_we  = 1'b1;
    @(negedge clk);
    input_fifo_we  = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [31:0] len);
    mode = m; ctx_length = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int t;
    t = 0;
    while (!done && t < budget) begin @(negedge clk); t++; end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !output_fifo_empty) && t < budget) begin @(negedge clk); t++; end
    tick(2);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [LW-1:0] vec, exp0, exp1, exp2, l, keep_a, keep_b;
  int t_pop, t_we, t;

  initial begin : stim
    vec  = mk_line(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3FC00000, 32'h0);
    exp0 = mk_line(32'hC0A00000, 32'h41200000, 32'h40900000, 32'h40C00000, 32'h0, 32'h0);
    exp1 = mk_line(32'h41300000, 32'h40000000, 32'h40900000, 32'h40C00000, 32'h0, 32'h0);
    exp2 = mk_line(32'hC0400000, 32'h40800000, 32'hC0E00000, 32'h41C00000, 32'h40100000, 32'h0);

    reset = 1'b1; start = 1'b0; mode = 2'd0; ctx_length = '0;
    input_fifo_din = '0; input_fifo_we = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state.
    check("rst_busy",         64'(busy), 64'd0);
    check("rst_done",         64'(done), 64'd0);
    check("rst_lines_out",    64'(lines_out), 64'd0);
    check("rst_in_count",     64'(input_fifo_count), 64'd0);
    check("rst_in_full",      64'(input_fifo_full), 64'd0);
    check("rst_in_afull",     64'(input_fifo_almost_full), 64'd0);
    check("rst_out_empty",    64'(output_fifo_empty), 64'd1);
    check("rst_out_aempty",   64'(output_fifo_almost_empty), 64'd1);
    check("rst_dout_nonzero", 64'(|output_fifo_dout), 64'd0);

    // Zero-length job: done one cycle after start, nothing popped.
    push_line(vec);
    start_job(2'd0, 32'd0);
    check("zero_len_done",  64'(done), 64'd1);
    check("zero_len_busy",  64'(busy), 64'd0);
    tick(3);
    check("zero_len_count", 64'(input_fifo_count), 64'd1);

    // Mode 0 ring, with pop-to-write latency measured at the FIFO boundaries.
    exp_q.push_back(exp0);
    start_job(2'd0, 32'd1);
    check("m0_busy", 64'(busy), 64'd1);
    t = 0;
    while (input_fifo_count != 3'd0 && t < 50) begin @(negedge clk); t++; end
    t_pop = cyc;
    t = 0;
    while (output_fifo_empty && t < 50) begin @(negedge clk); t++; end
    t_we = cyc;
    check("latency", 64'(t_we - t_pop), 64'd7);
    drain_en = 1'b1;
    wait_done("m0", 100);
    wait_drained("m0", 100);
    check("m0_lines_out", 64'(lines_out), 64'd1);

    // Mode 1 conjugate ring and mode 2 square.
    exp_q.push_back(exp1);
    push_line(vec);
    start_job(2'd1, 32'd1);
    wait_done("m1", 100);
    wait_drained("m1", 100);
    exp_q.push_back(exp2);
    push_line(vec);
    start_job(2'd2, 32'd1);
    wait_done("m2", 100);
    wait_drained("m2", 100);

    // Mode 3 passthrough of arbitrary bit patterns.
    for (int i = 0; i < 3; i++) begin l = rand_line(); exp_q.push_back(l); push_line(l); end
    start_job(2'd3, 32'd3);
    wait_done("m3", 100);
    wait_drained("m3", 100);
    check("m3_lines_out", 64'(lines_out), 64'd3);

    // Backpressure: output never popped, so only 8 lines may be written; start in RUN is ignored.
    drain_en = 1'b0;
    tick(2);
    start_job(2'd3, 32'd20);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          l = rand_line();
          exp_q.push_back(l);
          push_line(l);
        end
      end
      begin
        tick(80);
        check("bp_lines_out", 64'(lines_out), 64'd8);
        check("bp_in_full",   64'(input_fifo_full), 64'd1);
        check("bp_busy",      64'(busy), 64'd1);
        check("bp_out_aempty", 64'(output_fifo_almost_empty), 64'd0);
        start_job(2'd0, 32'd5);
        drain_en = 1'b1;
      end
    join
    wait_done("bp", 1000);
    wait_drained("bp", 200);
    check("bp_lines_total", 64'(lines_out), 64'd20);

    // 12 lines offered to a 10-line job: 2 remain for the next job.
    start_job(2'd3, 32'd10);
    for (int i = 0; i < 12; i++) begin
      l = rand_line();
      if (i < 10) exp_q.push_back(l);
      else if (i == 10) keep_a = l;
      else keep_b = l;
      push_line(l);
    end
    wait_done("len10", 500);
    wait_drained("len10", 200);
    check("len10_in_count",  64'(input_fifo_count), 64'd2);
    check("len10_lines_out", 64'(lines_out), 64'd10);
    exp_q.push_back(keep_a);
    exp_q.push_back(keep_b);
    start_job(2'd3, 32'd2);
    wait_done("len2", 200);
    wait_drained("len2", 200);
    check("len2_lines_out", 64'(lines_out), 64'd2);
    check("len2_in_count",  64'(input_fifo_count), 64'd0);

    // Reset mid-DRAIN with three lines in flight.
    drain_en = 1'b0;
    tick(3);
    for (int i = 0; i < 3; i++) push_line(vec);
    start_job(2'd2, 32'd3);
    t = 0;
    while (input_fifo_count != 3'd0 && t < 50) begin @(negedge clk); t++; end
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",      64'(busy), 64'd0);
    check("mid_rst_done",      64'(done), 64'd0);
    check("mid_rst_lines_out", 64'(lines_out), 64'd0);
    check("mid_rst_out_empty", 64'(output_fifo_empty), 64'd1);
    check("mid_rst_in_count",  64'(input_fifo_count), 64'd0);
    check("mid_rst_dout",      64'(|output_fifo_dout), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(20);
    check("post_rst_out_empty", 64'(output_fifo_empty), 64'd1);
    check("post_rst_lines_out", 64'(lines_out), 64'd0);
    check("post_rst_busy",      64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
